fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL provide parameter XLEN, default 32, meaning the data/address width.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL provide port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL provide mem_req, output, 1, instruction-memory read request.
REQ-006 SHALL provide mem_addr, output, XLEN, word-aligned read address.
REQ-007 SHALL provide mem_ack, input, 1, read data valid this cycle.
REQ-008 SHALL provide mem_rdata, input, XLEN, read data.
REQ-009 SHALL provide instruction, output, XLEN, held instruction word for the execute units.
REQ-010 SHALL provide program_counter, output, XLEN, address of the held instruction.
REQ-011 SHALL provide instr_valid, output, 1, instruction/program_counter valid.
REQ-012 SHALL provide instr_ready, input, 1, the execute stage retires the held instruction this cycle.
REQ-013 SHALL provide load_new_program_counter, input, 1, redirect request from the execute units (jalr, branches); may be z when no unit is enabled.
REQ-014 SHALL provide new_program_counter, input, XLEN, redirect target.
REQ-015 SHALL provide fetch_misaligned, output, 1, sticky flag: the redirect target had bit 1 set.
REQ-016 SHALL provide retired_count, output, XLEN, count of retired instructions.

Function
REQ-017 SHALL implement states FETCH (mem_req=1, mem_addr=pc) and HOLD (instr_valid=1, mem_req=0).
REQ-018 SHALL, in FETCH, on mem_ack: capture mem_rdata into instruction, latch pc into program_counter, enter HOLD next cycle; fetch latency = mem_ack cycle + 1.
REQ-019 SHALL hold mem_req and mem_addr stable in FETCH until mem_ack; mem_ack outside FETCH SHALL be ignored.
REQ-020 SHALL, in HOLD with instr_ready=1, retire: increment retired_count (wraps 32'hFFFF_FFFF -> 0), return to FETCH.
REQ-021 SHALL treat load_new_program_counter as asserted only when exactly 1'b1 (z/x/0 = not asserted).
REQ-022 SHALL, on retire with redirect asserted, set pc to {new_program_counter[XLEN-1:2], 2'b00}; otherwise pc = program_counter + 4 (mod 2^XLEN).
REQ-023 SHALL, on a redirect with new_program_counter[1]=1, set fetch_misaligned; it clears only on reset.
REQ-024 SHALL ignore load_new_program_counter when not retiring (instr_valid=0 or instr_ready=0).
REQ-025 SHALL ignore instr_ready while in FETCH.
REQ-026 SHALL keep instruction and program_counter unchanged in HOLD until retire.

Reset
REQ-027 SHALL, while reset=1 at posedge clk, set state=FETCH, pc=RESET_VECTOR, instruction=0, program_counter=0, instr_valid=0, retired_count=0, fetch_misaligned=0.
REQ-028 SHALL, on the first cycle after reset deasserts, drive mem_req=1 with mem_addr=RESET_VECTOR.
REQ-029 SHALL, on reset mid-fetch, discard any mem_ack in the reset cycle.

Structure
REQ-030 SHALL take XLEN and the fetch-state enum {FETCH, HOLD} from the shared CPU package.
REQ-031 SHALL contain no sub-modules; a single always_ff plus output decode.

Verification
REQ-032 SHALL verify reset: RESET_VECTOR=32'h100, release reset -> mem_req=1, mem_addr=32'h100 the next cycle.
REQ-033 SHALL verify sequential fetch: ack with 3-cycle memory delay, rdata=32'h0000_0013, instr_ready=1 -> instr_valid=1 for one cycle, program_counter=32'h100, next mem_addr=32'h104, retired_count=1.
REQ-034 SHALL verify redirect: retire with load_new_program_counter=1, new_program_counter=32'h2000 -> next mem_addr=32'h2000; with load_new_program_counter=z -> mem_addr=32'h104.
REQ-035 SHALL verify stall: instr_ready=0 for 5 cycles with a redirect pulse -> outputs stable, no mem_req, and the pulse is ignored.
REQ-036 SHALL verify misalignment and wrap: redirect to 32'h2002 -> mem_addr=32'h2000 and fetch_misaligned=1; pc=32'hFFFF_FFFC retire -> mem_addr=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared CPU definitions used by the fetch stage: the default
//                datapath width and the fetch state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Default data/address width of the CPU datapath.
    localparam int unsigned CPU_XLEN = 32;

    // Fetch stage states: FETCH waits on instruction memory, HOLD presents
    // the captured instruction to the execute units until it retires.
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Single-outstanding instruction fetch stage. Requests one word
//                from instruction memory, holds it for the execute units until
//                retired, then advances sequentially or to a redirect target.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned          XLEN         = CPU_XLEN,
    parameter logic [XLEN-1:0]      RESET_VECTOR = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    mem_req,
    output logic [XLEN-1:0]         mem_addr,
    input  logic                    mem_ack,
    input  logic [XLEN-1:0]         mem_rdata,
    output logic [XLEN-1:0]         instruction,
    output logic [XLEN-1:0]         program_counter,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    input  logic                    load_new_program_counter,
    input  logic [XLEN-1:0]         new_program_counter,
    output logic                    fetch_misaligned,
    output logic [XLEN-1:0]         retired_count
);

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);
    localparam logic [XLEN-1:0] c_one     = XLEN'(1);

    fetch_state_t     r_state;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_instruction;
    logic [XLEN-1:0]  r_program_counter;
    logic [XLEN-1:0]  r_retired_count;
    logic             r_fetch_misaligned;

    logic             w_redirect;
    logic [XLEN-1:0]  w_redirect_target;
    logic             w_unused_target_lsb;

    // The redirect line may float when no execute unit drives it, so only a
    // definite 1 counts as a request.
    assign w_redirect          = (load_new_program_counter === 1'b1);
    assign w_redirect_target   = {new_program_counter[XLEN-1:2], 2'b00};
    assign w_unused_target_lsb = new_program_counter[0];

    // Fetch/hold sequencing, retirement bookkeeping and next-pc selection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= FETCH;
            r_pc               <= RESET_VECTOR;
            r_instruction      <= '0;
            r_program_counter  <= '0;
            r_retired_count    <= '0;
            r_fetch_misaligned <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    // Request stays asserted at r_pc until memory answers.
                    if (mem_ack) begin
                        r_instruction     <= mem_rdata;
                        r_program_counter <= r_pc;
                        r_state           <= HOLD;
                    end
                end
                HOLD: begin
                    // Redirects are only honoured on the retiring cycle.
                    if (instr_ready) begin
                        r_retired_count <= r_retired_count + c_one;
                        r_state         <= FETCH;
                        if (w_redirect) begin
                            r_pc <= w_redirect_target;
                            if (new_program_counter[1]) begin
                                r_fetch_misaligned <= 1'b1;
                            end
                        end else begin
                            r_pc <= r_program_counter + c_pc_step;
                        end
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    // Output decode straight from registered state.
    assign mem_req          = (r_state == FETCH);
    assign mem_addr         = r_pc;
    assign instr_valid      = (r_state == HOLD);
    assign instruction      = r_instruction;
    assign program_counter  = r_program_counter;
    assign retired_count    = r_retired_count;
    assign fetch_misaligned = r_fetch_misaligned;

endmodule : fetch_unit
`default_nettype wire
